// File: rtl/proc_pkg.sv
// Shared definitions for the processor sequencer: phase encodings, opcodes
// and default datapath widths.
package proc_pkg;

  localparam int PC_W_DEF = 8;
  localparam int IR_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALTED    = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Control-flow opcodes and NOP have no register result.
  function automatic logic op_writes_rf(input logic [3:0] op);
    return !(op == OP_NOP || op == OP_JMP || op == OP_HALT);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Rising-edge detector for a divided clock sampled as data in the clk domain.
// A level already high when reset releases must fall once before it can tick.
module tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic lvl,
  output logic tick
);

  logic lvl_q;
  logic armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      lvl_q <= lvl;
      armed <= armed | ~lvl;
    end
  end

  assign tick = lvl & ~lvl_q & armed;

endmodule

// File: rtl/proc_sequencer.sv
// Fetch/decode/execute/writeback sequencer advancing one phase per rising
// edge of the divided processor clock; strobes decode from registered state.
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int PC_W = PC_W_DEF,
  parameter int IR_W = IR_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pro_clk,
  input  logic            run,
  input  logic            halt_req,
  input  logic [IR_W-1:0] instr_in,
  output logic [PC_W-1:0] pc,
  output logic [IR_W-1:0] ir,
  output logic            mem_rd,
  output logic            alu_en,
  output logic            rf_we,
  output logic [2:0]      state,
  output logic            halted
);

  logic            tick;
  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [3:0]      opcode;

  tick_gen u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .lvl  (pro_clk),
    .tick (tick)
  );

  assign opcode = ir_q[IR_W-1 -: 4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    if (tick) begin
      unique case (state_q)
        ST_IDLE, ST_HALTED: begin
          // halt_req dominates run so a held stop request keeps us parked.
          if (run && !halt_req) state_d = ST_FETCH;
        end
        ST_FETCH: begin
          state_d = ST_DECODE;
          ir_d    = instr_in;
        end
        ST_DECODE:  state_d = (opcode == OP_HALT) ? ST_HALTED : ST_EXECUTE;
        ST_EXECUTE: state_d = ST_WRITEBACK;
        ST_WRITEBACK: begin
          pc_d    = (opcode == OP_JMP) ? ir_q[PC_W-1:0] : pc_q + 1'b1;
          state_d = halt_req ? ST_HALTED : ST_FETCH;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_rd = 1'b0;
    alu_en = 1'b0;
    rf_we  = 1'b0;
    unique case (state_q)
      ST_FETCH:     mem_rd = 1'b1;
      ST_EXECUTE:   alu_en = 1'b1;
      ST_WRITEBACK: rf_we  = op_writes_rf(opcode);
      default: ;
    endcase
  end

  assign pc     = pc_q;
  assign ir     = ir_q;
  assign state  = state_q;
  assign halted = (state_q == ST_HALTED);

endmodule

// File: tb/tb_proc_sequencer.sv
// Scoreboard bench for proc_sequencer: an instruction-level model predicts
// the phase trace of a random program; a monitor checks every phase change.
module tb_proc_sequencer;
  import proc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pro_clk;
  logic        run;
  logic        halt_req;
  logic [15:0] instr_in;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic        mem_rd;
  logic        alu_en;
  logic        rf_we;
  logic [2:0]  state;
  logic        halted;

  proc_sequencer #(.PC_W(8), .IR_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .pro_clk  (pro_clk),
    .run      (run),
    .halt_req (halt_req),
    .instr_in (instr_in),
    .pc       (pc),
    .ir       (ir),
    .mem_rd   (mem_rd),
    .alu_en   (alu_en),
    .rf_we    (rf_we),
    .state    (state),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  // Free-running /4 divider, overridable to model a stuck pro_clk.
  logic [1:0] div_cnt = 2'd0;
  logic       div_force = 1'b0;
  logic       div_val = 1'b0;
  always @(posedge clk) div_cnt <= div_cnt + 2'd1;
  assign pro_clk = div_force ? div_val : div_cnt[1];

  logic [15:0] mem [256];
  assign instr_in = mem[pc];

  typedef struct {
    logic [2:0]  st;
    logic [7:0]  pc;
    logic [15:0] ir;
    bit          gap4;
  } rec_t;

  rec_t exp_q[$];
  rec_t cur;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  function automatic rec_t mk(logic [2:0] st, logic [7:0] p, logic [15:0] i, bit g);
    rec_t r;
    r.st = st; r.pc = p; r.ir = i; r.gap4 = g;
    return r;
  endfunction

  // Strobe table: {mem_rd, alu_en, rf_we, halted} expected in a phase.
  function automatic logic [3:0] exp_strobes(rec_t r);
    logic [3:0] op;
    logic       wr;
    op = r.ir[15:12];
    wr = (r.st == 3'd4) && (op != 4'h0) && (op != 4'hE) && (op != 4'hF);
    return {r.st == 3'd1, r.st == 3'd3, wr, r.st == 3'd5};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [2:0]  lst;
    logic [7:0]  lpc;
    logic [15:0] lir;
    int          gap;
    bit          was_en;
    was_en = 1'b0;
    lst = 3'd0; lpc = 8'd0; lir = 16'd0; gap = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        was_en = 1'b0;
        continue;
      end
      if (!was_en) begin
        was_en = 1'b1;
        cur = mk(3'd0, 8'd0, 16'd0, 1'b0);
        lst = 3'd0; lpc = 8'd0; lir = 16'd0; gap = 0;
      end
      gap++;
      if (state !== lst || pc !== lpc || ir !== lir) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_change: got state=%0d pc=%0h ir=%0h, expected state=%0d held",
                   state, pc, ir, lst);
        end else begin
          cur = exp_q.pop_front();
          check("state", 32'(state), 32'(cur.st));
          check("pc", 32'(pc), 32'(cur.pc));
          check("ir", 32'(ir), 32'(cur.ir));
          if (cur.gap4) check("tick_spacing", gap, 4);
        end
        gap = 0;
        lst = state; lpc = pc; lir = ir;
      end
      check("strobes", 32'({mem_rd, alu_en, rf_we, halted}), 32'(exp_strobes(cur)));
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    for (t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d pending phases, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic [7:0]  mpc;
    logic [7:0]  hpc;
    logic [15:0] mir;
    logic [15:0] instr;
    logic [3:0]  op;
    bit          hreq;
    bit          stopped;
    int          t;

    fork
      monitor();
    join_none

    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h00] = 16'h1234;
    mem[8'h01] = 16'hE0A5;
    mem[8'hA5] = 16'hE0FF;
    mem[8'hFF] = 16'h2000;

    rst = 1'b1; run = 1'b0; halt_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_ir", 32'(ir), 32'd0);
    check("rst_strobes", 32'({mem_rd, alu_en, rf_we}), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);

    rst = 1'b0;
    mon_en = 1'b1;
    repeat (10) @(negedge clk);

    mpc = 8'd0;
    mir = 16'd0;
    exp_q.push_back(mk(3'd1, mpc, mir, 1'b0));
    run = 1'b1;

    for (int k = 0; k < 70; k++) begin
      wait_drain("fetch");
      if (k == 4) begin
        // Back at pc 0 after the wrap: park on a HALT there, leave via a jump.
        mem[8'h00] = 16'hF000;
        mem[8'h01] = {8'hE0, 8'($urandom)};
      end
      instr = mem[mpc];
      op    = instr[15:12];
      hreq  = (op == 4'hF) || ($urandom_range(0, 3) == 0);
      halt_req = hreq;
      stopped  = 1'b0;
      hpc      = mpc;
      exp_q.push_back(mk(3'd2, mpc, instr, 1'b1));
      mir = instr;
      if (op == 4'hF) begin
        exp_q.push_back(mk(3'd5, mpc, instr, 1'b1));
        stopped = 1'b1;
      end else begin
        exp_q.push_back(mk(3'd3, mpc, instr, 1'b1));
        exp_q.push_back(mk(3'd4, mpc, instr, 1'b1));
        mpc = (op == 4'hE) ? instr[7:0] : mpc + 8'd1;
        if (hreq) begin
          exp_q.push_back(mk(3'd5, mpc, instr, 1'b1));
          stopped = 1'b1;
        end else begin
          exp_q.push_back(mk(3'd1, mpc, instr, 1'b1));
        end
      end
      if (stopped) begin
        wait_drain("halt");
        if (op == 4'hF) mem[hpc] = {4'($urandom_range(0, 14)), 12'($urandom)};
        // run and halt_req both high here: must stay parked.
        repeat ($urandom_range(3, 15)) @(negedge clk);
        exp_q.push_back(mk(3'd1, mpc, mir, 1'b0));
        halt_req = 1'b0;
      end
    end
    wait_drain("final");
    mon_en = 1'b0;
    halt_req = 1'b0;

    // Reset in the middle of a writeback phase must abort it at once.
    for (t = 0; t < 100 && state != 3'd4; t++) @(negedge clk);
    check("reach_writeback", 32'(state), 32'd4);
    rst = 1'b1;
    #1;
    check("abort_state", 32'(state), 32'd0);
    check("abort_pc", 32'(pc), 32'd0);
    check("abort_ir", 32'(ir), 32'd0);
    check("abort_rf_we", 32'(rf_we), 32'd0);

    div_force = 1'b1;
    div_val   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("stuck0_state", 32'(state), 32'd0);
    check("stuck0_pc", 32'(pc), 32'd0);

    rst = 1'b1;
    div_val = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("stuck1_state", 32'(state), 32'd0);
    check("stuck1_mem_rd", 32'(mem_rd), 32'd0);

    div_val = 1'b0;
    repeat (2) @(negedge clk);
    div_val = 1'b1;
    repeat (2) @(negedge clk);
    check("first_rise_state", 32'(state), 32'd1);
    check("first_rise_mem_rd", 32'(mem_rd), 32'd1);
    check("first_rise_pc", 32'(pc), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/proc_sequencer.md
PROC_SEQUENCER -- requirements
Module: proc_sequencer

Interface
REQ-001 Parameter: PC_W, default 8, program counter width.
REQ-002 Parameter: IR_W, default 16, instruction width; opcode is ir[IR_W-1:IR_W-4].
REQ-003 Port: clk  input  1  system clock, the same clock that drives the clock divider.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: pro_clk  input  1  divided processor clock from the divider; treated as data, never used as a clock.
REQ-006 Port: run  input  1  start/resume request, level.
REQ-007 Port: halt_req  input  1  stop request, honoured at the instruction boundary.
REQ-008 Port: instr_in  input  IR_W  instruction memory read data.
REQ-009 Port: pc  output  PC_W  program counter, also the instruction memory address.
REQ-010 Port: ir  output  IR_W  latched instruction.
REQ-011 Port: mem_rd  output  1  instruction fetch strobe.
REQ-012 Port: alu_en  output  1  execute-phase enable.
REQ-013 Port: rf_we  output  1  register-file write enable.
REQ-014 Port: state  output  3  current phase encoding.
REQ-015 Port: halted  output  1  sequencer is in HALTED.

Function
REQ-016 pro_clk SHALL be registered into pro_clk_q on every clk edge; tick = pro_clk AND NOT pro_clk_q.
REQ-017 State, pc and ir SHALL change only on a clk edge where tick=1, giving one state per pro_clk period (4 clk cycles with the /4 divider).
REQ-018 States and encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALTED=5.
REQ-019 IDLE or HALTED SHALL go to FETCH on tick with run=1 and halt_req=0; otherwise the state SHALL be held.
REQ-020 FETCH SHALL go to DECODE on tick, and ir SHALL load instr_in on that tick.
REQ-021 DECODE SHALL go to EXECUTE on tick, except when the opcode is 4'hF (HALT), in which case it SHALL go to HALTED.
REQ-022 EXECUTE SHALL go to WRITEBACK on tick.
REQ-023 On its exit tick, WRITEBACK SHALL do both of the following:
  - pc update: pc = ir[PC_W-1:0] when the opcode is 4'hE (JMP); otherwise pc = pc+1, wrapping from all-ones to 0.
  - next state: HALTED if halt_req=1, else FETCH.
REQ-024 A HALT opcode SHALL leave pc unchanged; on resume, the HALT instruction is refetched unless pc is changed externally (not supported).
REQ-025 Strobe levels by state:
  - mem_rd = 1 throughout FETCH.
  - alu_en = 1 throughout EXECUTE.
  - rf_we = 1 throughout WRITEBACK, except when the opcode is 4'h0 (NOP), 4'hE or 4'hF.
  - All strobes = 0 in every other state.
REQ-026 Strobes SHALL be decoded from registered state and ir only, with no path from any input.
REQ-027 halted SHALL equal (state==HALTED).
REQ-028 halt_req SHALL have no effect except in IDLE, HALTED and at the WRITEBACK exit tick.
REQ-029 If run and halt_req are both 1 in IDLE or HALTED, halt_req SHALL win and the state SHALL be held.
REQ-030 If pro_clk is stuck at 0 or stuck at 1, no tick SHALL occur and all state SHALL be frozen.

Reset
REQ-031 While rst=1, outputs SHALL be: state=IDLE, pc=0, ir=0, pro_clk_q=0, and all strobes 0.
REQ-032 Reset asserted mid-instruction SHALL abort immediately; no partial writeback and no pc update.
REQ-033 After reset release, the first tick SHALL require pro_clk to rise from 0; a pro_clk already at 1 produces no tick.

Structure
REQ-034 State encodings, opcode constants (NOP=4'h0, JMP=4'hE, HALT=4'hF) and default widths SHALL reside in shared package proc_pkg.
REQ-035 The edge detector SHALL be a sub-module tick_gen (inputs clk, rst, lvl; output tick), reusable for reg_clk.
REQ-036 Implementation: a single FSM with a registered datapath and a combinational strobe decode.

Verification
REQ-037 Reset, then run=1 with instr_in=16'h1234 and the divider free-running -> states 1,2,3,4 at 4-clk spacing; ir=16'h1234; rf_we high for 4 clk; pc 0->1.
REQ-038 instr_in=16'hE0A5 -> after WRITEBACK, pc=8'hA5; rf_we never asserted.
REQ-039 pc=8'hFF with a non-JMP instruction -> after WRITEBACK, pc=8'h00.
REQ-040 halt_req=1 during EXECUTE -> WRITEBACK completes, then HALTED, halted=1; raising run=1 with halt_req=0 -> FETCH on the next tick.
REQ-041 instr_in=16'hF000 -> DECODE goes to HALTED; alu_en and rf_we never asserted; pc unchanged.
REQ-042 rst pulsed during WRITEBACK of pc=5 -> pc=0, state=IDLE, rf_we drops in the same cycle; pro_clk held at 0 -> no state change.
